// File: rtl/bitcoin_host.sv
// Job-side controller for the nonce-search hasher: loads a block header into shared memory,
// kicks the hasher, then scans the 16 per-nonce H0 words for the lowest hash.
`timescale 1ns/1ps
module bitcoin_host #(
  parameter logic [15:0] MSG_BASE   = 16'h0000,
  parameter logic [15:0] OUT_BASE   = 16'h0040,
  parameter int          HDR_WORDS  = 19,
  parameter int          NUM_NONCES = 16
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        job_valid,
  output logic        job_ready,
  input  logic [31:0] job_data,
  input  logic [31:0] target,
  output logic [15:0] message_addr,
  output logic [15:0] output_addr,
  output logic        hash_start,
  input  logic        hash_done,
  output logic        mem_own,
  output logic        mem_we,
  output logic [15:0] mem_addr,
  output logic [31:0] mem_write_data,
  input  logic [31:0] mem_read_data,
  output logic        res_valid,
  output logic        res_found,
  output logic [3:0]  res_nonce,
  output logic [31:0] res_hash,
  output logic        busy
);

  localparam logic [2:0] S_LOAD   = 3'd0;
  localparam logic [2:0] S_START  = 3'd1;
  localparam logic [2:0] S_WAIT   = 3'd2;
  localparam logic [2:0] S_READ   = 3'd3;
  localparam logic [2:0] S_REPORT = 3'd4;

  localparam logic [4:0] LAST_IDX   = 5'(HDR_WORDS - 1);
  localparam logic [4:0] LAST_NONCE = 5'(NUM_NONCES - 1);

  logic [2:0]  state_r;
  logic [4:0]  idx_r;
  logic [4:0]  cnt_r;
  logic [31:0] target_r;
  logic [31:0] best_r;
  logic [3:0]  best_nonce_r;
  logic        done_q_r;
  logic        hash_start_r;
  logic        mem_own_r;
  logic        mem_we_r;
  logic [15:0] mem_addr_r;
  logic [31:0] mem_write_data_r;
  logic        res_valid_r;
  logic        res_found_r;
  logic [3:0]  res_nonce_r;
  logic [31:0] res_hash_r;

  logic        accept_s;
  logic        done_rise_s;
  logic [3:0]  cap_nonce_s;
  logic        take_s;
  logic [31:0] next_best_s;
  logic [3:0]  next_nonce_s;

  assign message_addr   = MSG_BASE;
  assign output_addr    = OUT_BASE;
  assign hash_start     = hash_start_r;
  assign mem_own        = mem_own_r;
  assign mem_we         = mem_we_r;
  assign mem_addr       = mem_addr_r;
  assign mem_write_data = mem_write_data_r;
  assign res_valid      = res_valid_r;
  assign res_found      = res_found_r;
  assign res_nonce      = res_nonce_r;
  assign res_hash       = res_hash_r;

  // Handshake, done edge and running-minimum compare of the word arriving this cycle
  always_comb begin
    job_ready   = (state_r == S_LOAD);
    busy        = (state_r != S_LOAD);
    accept_s    = job_valid && job_ready;
    done_rise_s = hash_done && !done_q_r;
    // capture lags the read counter by one; REPORT sees cnt_r=16 and so nonce 15
    cap_nonce_s = 4'(cnt_r - 5'd1);
    if (cap_nonce_s == 4'd0) begin
      take_s = 1'b1;
    end else begin
      take_s = (mem_read_data < best_r);
    end
    if (take_s) begin
      next_best_s  = mem_read_data;
      next_nonce_s = cap_nonce_s;
    end else begin
      next_best_s  = best_r;
      next_nonce_s = best_nonce_r;
    end
  end

  // Job sequencer: header write, start pulse, done wait, result scan and report
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r          <= S_LOAD;
      idx_r            <= 5'd0;
      cnt_r            <= 5'd0;
      target_r         <= 32'd0;
      best_r           <= 32'd0;
      best_nonce_r     <= 4'd0;
      done_q_r         <= 1'b0;
      hash_start_r     <= 1'b0;
      mem_own_r        <= 1'b1;
      mem_we_r         <= 1'b0;
      mem_addr_r       <= 16'd0;
      mem_write_data_r <= 32'd0;
      res_valid_r      <= 1'b0;
      res_found_r      <= 1'b0;
      res_nonce_r      <= 4'd0;
      res_hash_r       <= 32'd0;
    end else begin
      done_q_r <= hash_done;
      case (state_r)
        S_LOAD: begin
          mem_own_r   <= 1'b1;
          res_valid_r <= 1'b0;
          if (accept_s) begin
            mem_we_r         <= 1'b1;
            mem_addr_r       <= MSG_BASE + {11'd0, idx_r};
            mem_write_data_r <= job_data;
            if (idx_r == 5'd0) begin
              target_r <= target;
            end
            if (idx_r == LAST_IDX) begin
              idx_r   <= 5'd0;
              state_r <= S_START;
            end else begin
              idx_r <= idx_r + 5'd1;
            end
          end else begin
            mem_we_r <= 1'b0;
          end
        end
        S_START: begin
          mem_we_r     <= 1'b0;
          mem_own_r    <= 1'b0;
          hash_start_r <= 1'b1;
          state_r      <= S_WAIT;
        end
        S_WAIT: begin
          hash_start_r <= 1'b0;
          if (done_rise_s) begin
            mem_own_r  <= 1'b1;
            mem_addr_r <= OUT_BASE;
            cnt_r      <= 5'd0;
            state_r    <= S_READ;
          end
        end
        S_READ: begin
          cnt_r <= cnt_r + 5'd1;
          if (cnt_r < LAST_NONCE) begin
            mem_addr_r <= OUT_BASE + {11'd0, cnt_r + 5'd1};
          end
          if (cnt_r != 5'd0) begin
            best_r       <= next_best_s;
            best_nonce_r <= next_nonce_s;
          end
          if (cnt_r == LAST_NONCE) begin
            state_r <= S_REPORT;
          end
        end
        S_REPORT: begin
          res_hash_r  <= next_best_s;
          res_nonce_r <= next_nonce_s;
          res_found_r <= (next_best_s < target_r);
          res_valid_r <= 1'b1;
          idx_r       <= 5'd0;
          state_r     <= S_LOAD;
        end
        default: begin
          state_r <= S_LOAD;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bitcoin_host.sv
// Directed self-checking bench for bitcoin_host with a small synchronous word memory model.
`timescale 1ns/1ps
module tb_bitcoin_host;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        job_valid = 1'b0;
  logic        job_ready;
  logic [31:0] job_data = 32'd0;
  logic [31:0] target = 32'd0;
  logic [15:0] message_addr;
  logic [15:0] output_addr;
  logic        hash_start;
  logic        hash_done = 1'b0;
  logic        mem_own;
  logic        mem_we;
  logic [15:0] mem_addr;
  logic [31:0] mem_write_data;
  logic [31:0] mem_read_data = 32'd0;
  logic        res_valid;
  logic        res_found;
  logic [3:0]  res_nonce;
  logic [31:0] res_hash;
  logic        busy;

  int checks = 0;
  int errors = 0;

  logic [31:0] hdr_mem [0:31];
  logic [31:0] res_mem [0:15];

  bitcoin_host dut (
    .clk(clk), .reset_n(reset_n), .job_valid(job_valid), .job_ready(job_ready),
    .job_data(job_data), .target(target), .message_addr(message_addr),
    .output_addr(output_addr), .hash_start(hash_start), .hash_done(hash_done),
    .mem_own(mem_own), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_write_data(mem_write_data), .mem_read_data(mem_read_data),
    .res_valid(res_valid), .res_found(res_found), .res_nonce(res_nonce),
    .res_hash(res_hash), .busy(busy)
  );

  always #5 clk = ~clk;

  // Header region is written by the DUT; result region is preloaded by the stimulus
  always @(posedge clk) begin
    if (mem_own && mem_we && mem_addr < 16'd32) hdr_mem[mem_addr[4:0]] <= mem_write_data;
    if (mem_addr >= 16'h0040 && mem_addr < 16'h0050) mem_read_data <= res_mem[mem_addr[3:0]];
    else if (mem_addr < 16'd32) mem_read_data <= hdr_mem[mem_addr[4:0]];
    else mem_read_data <= 32'hDEAD_BEEF;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic load_header(input logic [31:0] tgt, input bit bp, input bit done_pre);
    target = tgt;
    for (int i = 0; i < 19; i++) begin
      if (bp) begin
        job_valid = 1'b0;
        job_data  = 32'h5555_5555;
        step;
        check("bp_idle_we", {31'd0, mem_we}, 32'd0);
      end
      job_valid = 1'b1;
      job_data  = 32'(i);
      if (i == 18 && done_pre) hash_done = 1'b1;
      check("load_ready", {31'd0, job_ready}, 32'd1);
      step;
      check("wr_we", {31'd0, mem_we}, 32'd1);
      check("wr_addr", {16'd0, mem_addr}, 32'(i));
      check("wr_data", mem_write_data, 32'(i));
      // target must only be taken with header word 0
      target = ~tgt;
    end
    job_valid = 1'b0;
  endtask

  task automatic run_hash(input bit done_pre, input logic [31:0] exp_hash,
                          input logic [3:0] exp_nonce, input logic exp_found);
    job_valid = 1'b1;
    job_data  = 32'hBAD0_0000;
    step;
    check("start_pulse", {31'd0, hash_start}, 32'd1);
    check("start_own", {31'd0, mem_own}, 32'd0);
    check("start_we", {31'd0, mem_we}, 32'd0);
    check("start_busy", {31'd0, busy}, 32'd1);
    check("start_ready", {31'd0, job_ready}, 32'd0);
    step;
    check("start_drop", {31'd0, hash_start}, 32'd0);
    check("wait_we", {31'd0, mem_we}, 32'd0);
    if (done_pre) begin
      for (int i = 0; i < 3; i++) begin
        step;
        check("held_done_own", {31'd0, mem_own}, 32'd0);
      end
      hash_done = 1'b0;
    end
    repeat (10) step;
    check("wait_own", {31'd0, mem_own}, 32'd0);
    hash_done = 1'b1;
    step;
    check("read_own", {31'd0, mem_own}, 32'd1);
    check("read_addr0", {16'd0, mem_addr}, 32'h0000_0040);
    for (int k = 1; k < 16; k++) begin
      step;
      check("read_addr", {16'd0, mem_addr}, 32'h0000_0040 + 32'(k));
      check("read_nores", {31'd0, res_valid}, 32'd0);
    end
    step;
    check("res_early", {31'd0, res_valid}, 32'd0);
    step;
    check("res_valid", {31'd0, res_valid}, 32'd1);
    check("res_hash", res_hash, exp_hash);
    check("res_nonce", {28'd0, res_nonce}, {28'd0, exp_nonce});
    check("res_found", {31'd0, res_found}, {31'd0, exp_found});
    hash_done = 1'b0;
    job_valid = 1'b0;
    step;
    check("res_pulse", {31'd0, res_valid}, 32'd0);
    check("idle_busy", {31'd0, busy}, 32'd0);
    check("idle_ready", {31'd0, job_ready}, 32'd1);
    check("idle_own", {31'd0, mem_own}, 32'd1);
    check("res_hold", res_hash, exp_hash);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    #12;
    check("rst_ready", {31'd0, job_ready}, 32'd1);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_own", {31'd0, mem_own}, 32'd1);
    check("rst_we", {31'd0, mem_we}, 32'd0);
    check("rst_start", {31'd0, hash_start}, 32'd0);
    check("rst_valid", {31'd0, res_valid}, 32'd0);
    check("rst_found", {31'd0, res_found}, 32'd0);
    check("rst_addr", {16'd0, mem_addr}, 32'd0);
    check("rst_wdata", mem_write_data, 32'd0);
    check("rst_nonce", {28'd0, res_nonce}, 32'd0);
    check("rst_hash", res_hash, 32'd0);
    check("msg_addr", {16'd0, message_addr}, 32'h0000_0000);
    check("out_addr", {16'd0, output_addr}, 32'h0000_0040);
    step;
    reset_n = 1'b1;
    step;

    // Job 1: unsigned minimum at nonce 9, done held high through START
    for (int n = 0; n < 16; n++) res_mem[n] = 32'hF000_0000 - 32'(n * 16);
    res_mem[9] = 32'h0000_1234;
    load_header(32'h0001_0000, 1'b0, 1'b1);
    run_hash(1'b1, 32'h0000_1234, 4'd9, 1'b1);
    for (int i = 0; i < 19; i++) check("hdr_mem", hdr_mem[i], 32'(i));

    // Job 2: backpressure, all-equal words, target equal to hash
    for (int n = 0; n < 16; n++) res_mem[n] = 32'h0000_5000;
    load_header(32'h0000_5000, 1'b1, 1'b0);
    run_hash(1'b0, 32'h0000_5000, 4'd0, 1'b0);

    // Job 3: target zero never finds
    load_header(32'h0000_0000, 1'b0, 1'b0);
    run_hash(1'b0, 32'h0000_5000, 4'd0, 1'b0);

    // Job 4: minimum in the last slot, a large MSB-set word in between
    for (int n = 0; n < 16; n++) res_mem[n] = 32'h0000_0100;
    res_mem[3]  = 32'h8000_0000;
    res_mem[15] = 32'h0000_0005;
    load_header(32'h0000_0010, 1'b0, 1'b0);
    run_hash(1'b0, 32'h0000_0005, 4'd15, 1'b1);

    // Reset in the middle of READ
    load_header(32'h0000_1000, 1'b0, 1'b0);
    step;
    step;
    hash_done = 1'b1;
    step;
    repeat (5) step;
    check("midread_own_pre", {31'd0, mem_own}, 32'd1);
    reset_n = 1'b0;
    #1;
    check("mr_own", {31'd0, mem_own}, 32'd1);
    check("mr_ready", {31'd0, job_ready}, 32'd1);
    check("mr_valid", {31'd0, res_valid}, 32'd0);
    check("mr_start", {31'd0, hash_start}, 32'd0);
    check("mr_busy", {31'd0, busy}, 32'd0);
    check("mr_addr", {16'd0, mem_addr}, 32'd0);
    check("mr_hash", res_hash, 32'd0);
    hash_done = 1'b0;
    step;
    check("mr_addr_hold", {16'd0, mem_addr}, 32'd0);
    reset_n = 1'b1;
    step;
    load_header(32'h0000_0010, 1'b0, 1'b0);
    run_hash(1'b0, 32'h0000_0005, 4'd15, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/bitcoin_host.md
# bitcoin_host

Job-side controller for the nonce-search hasher. It accepts a 19-word block header as a valid/ready stream and writes it into the shared word memory. It then pulses the hasher's start, waits for its done, and reads back the 16 per-nonce H0 words. It reports the lowest hash, its nonce, and whether that hash beats a 32-bit target. It sits between the host/stream side and the hasher, and owns the shared memory bus whenever the hasher is idle.

## Interface
Parameters:
- MSG_BASE, 16'h0000, memory word address of header word 0
- OUT_BASE, 16'h0040, memory word address of the nonce-0 result; nonce n is at OUT_BASE+n
- HDR_WORDS, 19, header words per job
- NUM_NONCES, 16, results read back per job

Ports:
- clk  in  1  single clock, also drives memory
- reset_n  in  1  asynchronous, active-low reset
- job_valid  in  1  header word valid
- job_ready  out  1  header word accepted when valid & ready
- job_data  in  32  header word
- target  in  32  threshold, sampled with header word 0
- message_addr  out  16  constant MSG_BASE, to hasher
- output_addr  out  16  constant OUT_BASE, to hasher
- hash_start  out  1  one-cycle start pulse to hasher
- hash_done  in  1  hasher completion
- mem_own  out  1  1 = this block drives the memory bus (top-level mux select)
- mem_we  out  1  write enable
- mem_addr  out  16  word address
- mem_write_data  out  32  write data
- mem_read_data  in  32  read data; synchronous memory, valid one cycle after the address is presented
- res_valid  out  1  one-cycle result strobe
- res_found  out  1  res_hash < target
- res_nonce  out  4  nonce of the lowest hash
- res_hash  out  32  lowest H0 word
- busy  out  1  state != LOAD

## Operation
- States: LOAD, START, WAIT, READ, REPORT. All outputs are registered except job_ready (LOAD only) and busy.
- LOAD:
  - mem_own=1. Each accepted word idx (0..18) writes mem_addr=MSG_BASE+idx, mem_we=1 for exactly one cycle. Otherwise mem_we=0.
  - target is latched on idx 0.
  - The accept of idx 18 moves to START.
- START (1 cycle): mem_we<=0, mem_own<=0, hash_start<=1, then WAIT.
- WAIT:
  - hash_start<=0.
  - A rising edge of hash_done (hash_done & ~done_q) moves to READ with mem_own<=1, mem_addr<=OUT_BASE.
  - done_q is registered every cycle in every state.
- READ:
  - Addresses OUT_BASE+0..15 are issued on consecutive cycles.
  - The word for address k is captured two edges after it is issued.
  - Compare (unsigned): a strictly smaller word replaces the best. Ties keep the lower nonce, so nonce 0 seeds the best.
- REPORT: on the capture of word 15, res_hash/res_nonce/res_found are updated with the final compare and res_valid<=1 for one cycle. Then LOAD.
- res_* hold until the next REPORT.
- res_found = best < target (strict); target=0 never finds.

## Timing
- Reset values:
  - State LOAD, idx 0.
  - job_ready=1, busy=0, mem_own=1.
  - mem_we, hash_start, res_valid, res_found = 0.
  - mem_addr, mem_write_data, res_nonce, res_hash = 0.
  - done_q=0.
- Reset mid-job: immediate return to LOAD and the partial header is discarded. The hasher shares reset_n.
- job_valid outside LOAD is ignored (job_ready=0). Back-to-back accepts give back-to-back writes with no bubbles.
- Accept of word 18 at edge E0:
  - Its write is presented in cycle E0..E1.
  - hash_start and mem_own=0 are presented in cycle E1..E2; the hasher samples start at E2.
- hash_done rising, sampled at edge D:
  - Address k is presented after D+k.
  - Data k is captured at D+k+2.
  - res_valid is high in cycle D+17..D+18.
- hash_done high in LOAD/START, or held high continuously from before START, does not trigger. Only a low-to-high edge inside WAIT does.
- Widths: the address adds are 16-bit and wrap modulo 2^16. res_nonce is a 4-bit counter value.

## Test plan
- Reset: drive reset_n=0 mid-READ -> next cycle mem_own=1, job_ready=1, res_valid=0, hash_start=0; no further memory reads.
- Header load: stream words 32'h0000_0000+idx with valid held high -> mem_we high for 19 consecutive cycles at addresses 0..18 with the matching data. Exactly one hash_start pulse follows, coincident with mem_own=0.
- Backpressure: toggle job_valid every other cycle -> writes only on accept cycles; idx never skips.
- Done edge: hold hash_done=1 through START, drop it, raise it 10 cycles later -> READ starts only after the rise; res_valid comes 17 cycles after the rise edge.
- Result: memory OUT_BASE+n = 32'hF000_0000-n·16, except word 9 = 32'h0000_1234; target=32'h0001_0000 -> res_hash=32'h0000_1234, res_nonce=9, res_found=1.
- Ties and threshold:
  - All 16 words 32'h0000_5000, target=32'h0000_5000 -> res_nonce=0, res_found=0 (strict).
  - The same words with target=0 -> res_found=0.
